// File: rtl/uart_tx_arbiter.sv
// Two-port arbiter feeding a single UART TX core: frame-atomic grants with a
// hold-off timer and a per-grant burst limit that forces round-robin.
module uart_tx_arbiter #(
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_BURST   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_accept,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_accept,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant_o,
  output logic       arb_busy_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      grant_reg, grant_next;
  logic            last_grant_reg, last_grant_next;   // 1 = port B
  logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            tx_start_reg;
  logic [7:0]      tx_data_reg, tx_data_next;

  logic [1:0]      valid_vec, accept_vec;
  logic            gnt_valid, oth_valid;
  logic [7:0]      gnt_data;

  assign valid_vec = {b_valid, a_valid};
  assign gnt_valid = |(grant_reg & valid_vec);
  assign oth_valid = |({grant_reg[0], grant_reg[1]} & valid_vec);
  assign gnt_data  = grant_reg[1] ? b_data : a_data;

  // Accept only ever fires for the granted port while loading its byte.
  for (genvar gi = 0; gi < 2; gi++) begin : g_accept
    assign accept_vec[gi] = (state_reg == LOAD) && grant_reg[gi] && valid_vec[gi];
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    tx_data_next    = tx_data_reg;
    case (state_reg)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant_next = last_grant_reg ? 2'b01 : 2'b10;
        end else if (a_valid) begin
          grant_next = 2'b01;
        end else if (b_valid) begin
          grant_next = 2'b10;
        end
        if (a_valid || b_valid) begin
          burst_cnt_next = '0;
          state_next     = LOAD;
        end
      end
      LOAD: begin
        tx_data_next    = gnt_data;
        burst_cnt_next  = burst_cnt_reg + BW'(1);
        last_grant_next = grant_reg[1];
        state_next      = START;
      end
      START: state_next = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (gnt_valid) begin
            state_next = LOAD;
            // Burst exhausted: restart the count, and hand over if the other side waits.
            if (burst_cnt_reg == BW'(MAX_BURST)) begin
              burst_cnt_next = '0;
              if (oth_valid) grant_next = {grant_reg[0], grant_reg[1]};
            end
          end else begin
            hold_cnt_next = '0;
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        if (gnt_valid) begin
          state_next = LOAD;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
          if (hold_cnt_reg == HW'(HOLD_CYCLES - 1)) begin
            grant_next = 2'b00;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
      burst_cnt_reg  <= '0;
      hold_cnt_reg   <= '0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= 8'h00;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      tx_start_reg   <= (state_next == START);
      tx_data_reg    <= tx_data_next;
    end
  end

  assign a_accept   = accept_vec[0];
  assign b_accept   = accept_vec[1];
  assign tx_start   = tx_start_reg;
  assign tx_data    = tx_data_reg;
  assign grant_o    = grant_reg;
  assign arb_busy_o = (state_reg != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter core between two byte sources: port A, the CPU TX FIFO, and port B, the telemetry frame source. Each byte is taken through a valid/accept handshake and sequenced into the TX core as a `tx_start` pulse, then a wait through the core's `tx_busy` high/low cycle. Arbitration is frame-atomic: a grant is held while its requester keeps data flowing, bounded by a burst limit. It sits between the FIFO-side `req_valid`/`req_data`/`req_accept` interfaces and the serializer.

## Interface
- `HOLD_CYCLES`, default 8: idle cycles a granted port may go without `valid` before its grant is released; must be ≥1.
- `MAX_BURST`, default 64: maximum bytes per grant before forced re-arbitration when the other port is requesting; must be ≥1.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  port A has a byte; held until accepted.
- `a_data`  in  8  port A byte; stable while `a_valid`.
- `a_accept`  out  1  port A byte consumed this cycle (combinational, one cycle).
- `b_valid`  in  1  port B has a byte.
- `b_data`  in  8  port B byte.
- `b_accept`  out  1  port B byte consumed this cycle.
- `tx_start`  out  1  one-cycle registered start pulse to the TX core.
- `tx_data`  out  8  registered byte to transmit; stable from `tx_start` until the next LOAD.
- `tx_busy`  in  1  TX core is shifting a byte.
- `grant_o`  out  2  one-hot current owner ({B,A}); 2'b00 when none.
- `arb_busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, HOLD.
- **IDLE:**
  - If exactly one `valid` is high, grant that port.
  - If both are high, grant the port ≠ `last_grant` (round-robin).
  - On a grant: set `grant`, clear `burst_cnt`, go to LOAD.
- **LOAD:** entered only when the granted `valid` is high.
  - Assert that port's `accept` combinationally.
  - `tx_data <= data`; `burst_cnt <= burst_cnt+1`; `last_grant <= grant`.
  - Go to START.
- **START:** `tx_start`=1 for exactly this cycle; go to WAIT_HI.
- **WAIT_HI:** wait for `tx_busy`=1, then go to WAIT_LO.
- **WAIT_LO:** wait for `tx_busy`=0, then decide:
  - Granted `valid` high and `burst_cnt` < MAX_BURST: go to LOAD (same grant).
  - Granted `valid` high, `burst_cnt` == MAX_BURST, other `valid` high: switch grant to the other port, clear `burst_cnt`, go to LOAD.
  - Granted `valid` high, `burst_cnt` == MAX_BURST, other `valid` low: clear `burst_cnt`, go to LOAD (same grant).
  - Granted `valid` low: clear `hold_cnt`, go to HOLD.
- **HOLD:** grant is retained and the other port is ignored (frame atomicity).
  - Granted `valid` high: go to LOAD. `burst_cnt` is not cleared.
  - Otherwise `hold_cnt++`. When `hold_cnt` == HOLD_CYCLES-1 and `valid` is still low, release: `grant` ← 00, go to IDLE.
- Counter widths:
  - `burst_cnt` is $clog2(MAX_BURST+1) bits.
  - `hold_cnt` is $clog2(HOLD_CYCLES+1) bits.
  - Neither counter wraps; both are saturation-free because of the bounds above.
- `accept` is never asserted outside LOAD and never to the non-granted port. At most one `accept` is high per cycle.
- A requester dropping `valid` without an accept is a protocol violation; behaviour is undefined.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `tx_start`=0, `tx_data`=8'h00, `grant_o`=2'b00.
  - `a_accept`=`b_accept`=0, `arb_busy_o`=0.
  - `burst_cnt`=0, `hold_cnt`=0, `last_grant`=B, so port A wins the first tie.
- Reset asserted mid-transfer: all state returns to reset values immediately. Any byte already handed to the TX core is not re-sent, and no accept is generated.
- Latency from IDLE:
  - Cycle 0: `valid` seen in IDLE.
  - Cycle 1: LOAD with `accept`=1.
  - Cycle 2: `tx_start`=1 with `tx_data` valid.
- Back-to-back bytes: `tx_busy` is sampled low in WAIT_LO at cycle n, then LOAD at n+1 and `tx_start` at n+2.
- WAIT_HI has no timeout. The TX core must raise `tx_busy` within a bounded number of cycles after `tx_start`.
- HOLD release: with `valid` low for HOLD_CYCLES consecutive HOLD cycles, IDLE is reached on the following cycle.
- `grant_o` changes only on IDLE→LOAD, on a WAIT_LO switch, or on HOLD→IDLE.

## Test plan
- **Single byte on A.** Reset, then `a_valid`=1 with `a_data`=8'h55 for one accept. Expect `a_accept` at cycle 1, `tx_start` at cycle 2 with `tx_data`=8'h55, `grant_o`=01. After the modelled `tx_busy` pulse and HOLD_CYCLES idle cycles, expect `grant_o`=00 and `arb_busy_o`=0.
- **Simultaneous request.** `a_valid` and `b_valid` both rise in IDLE right after reset. Expect A granted first. After A's stream ends and its grant is released, with B still valid, expect B granted.
- **Frame atomicity.** Grant held by A, with A pausing HOLD_CYCLES-2 cycles between bytes while `b_valid`=1. Expect no `b_accept` until A's grant is released.
- **Burst limit.** MAX_BURST=4, A continuously valid, B valid. Expect exactly 4 `a_accept`s, then `grant_o`=10 and a `b_accept`. With B idle instead, expect A to continue uninterrupted with `burst_cnt` restarting.
- **Reset mid-operation.** Assert `rst_n`=0 while in WAIT_LO. Expect all outputs at reset values in the same cycle, and no `accept` after release until a new `valid` appears.
- **Back-to-back cadence.** `tx_busy` model of 10 cycles per byte, 3 bytes from B. Expect `tx_start` spacing of 10+3 cycles, `tx_data` 8'hA1, 8'hA2, 8'hA3 in order, and exactly 3 `b_accept` pulses.
